qft3_top: RTL and testbench
===========================

Name: qft3_top

Overview:
- Fully pipelined 3-qubit Quantum Fourier Transform datapath.
- Takes an 8-amplitude complex state vector in signed Q4.12 and produces its QFT, f_k = (1/sqrt8)·Σ_j x_j·e^{+i·2π·j·k/8}, with the bit-reversal swap included so outputs are in natural order.
- Top-level block of the QFT accelerator; accepts one vector per clock.

Parameters:
- TOTAL_WIDTH, 16, width of each real/imag fixed-point word (shared header `TOTAL_WIDTH`).
- FRAC_WIDTH, 12, fractional bits (Q4.12; 1.0 = 4096).
- LATENCY, 8, cycles from valid_in sampled high to valid_out high (fixed, not runtime-configurable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  input vector valid; sampled every rising edge.
- iXYZ_r, iXYZ_i (XYZ = 000..111, 16 ports)  in  TOTAL_WIDTH each  signed real/imag amplitude of basis state |XYZ>. X is the MSB, so index j = 4X+2Y+Z.
- fXYZ_r, fXYZ_i (XYZ = 000..111, 16 ports)  out  TOTAL_WIDTH each  signed real/imag of output amplitude k = XYZ, registered.
- valid_out  out  1  one-cycle pulse per accepted input vector.

Behaviour:
- Reset (rst=1 at a clk edge): valid_out=0, all f* outputs=0, and every internal valid stage is cleared.
- Any vector in flight is discarded; no valid_out is produced for it.
- Vectors presented in the same cycle as rst=1 are ignored.
- Handshake: no backpressure.
  - Vector accepted on any edge with valid_in=1 and rst=0.
  - Back-to-back vectors on consecutive cycles are supported: throughput 1 vector/cycle, no gaps required.
- Latency:
  - An input sampled at edge N produces valid_out=1 and its results on f* after edge N+LATENCY (i.e. 8).
  - valid_out lasts exactly 1 cycle per accepted vector.
  - Order is preserved.
- Output hold: f* update only on edges where a result becomes valid; otherwise they hold the last result.
- Data while valid_in=0 is don't-care and must not disturb the pipeline.
- Structure (recommended, the final math is binding):
  - H(q2), CP(π/2)(q1→q2), CP(π/4)(q0→q2), H(q1), CP(π/2)(q0→q1), H(q0), then swap q0↔q2.
  - Alternatively a direct 8-point DFT with twiddles W^m = e^{iπm/4}.
  - Register stages are distributed to meet LATENCY exactly.
- Arithmetic:
  - Constants in Q12: 1/√2 = 2896, 1/√8 = 1448.
  - Internal products are kept at full width (≥ 2·TOTAL_WIDTH+3); intermediate sums must not overflow.
  - The final result is rounded to nearest (ties away from zero), shifted right by FRAC_WIDTH, and saturated to the signed TOTAL_WIDTH range [-32768, 32767].
  - Accuracy: every output is within ±2 LSB of the ideal real-valued f_k·4096.
  - Exact values are required for the canonical cases in the Test Plan.
- Normalisation: each H applies the 1/√2 factor, so a unit-norm input gives a unit-norm output.
- Boundary cases:
  - Full-scale inputs (±7.999) saturate rather than wrap.
  - All-zero input gives all-zero output.
  - Reset asserted mid-stream flushes the pipeline; the first valid_out after release appears LATENCY cycles after the first post-reset valid_in.

Test Plan:
- Reset for 3 cycles, then idle 10 cycles -> valid_out stays 0; all f* = 0.
- |000> (i000_r=4096, all others 0), one-cycle valid_in -> 8 cycles later valid_out pulses once; every fXYZ = (1448, 0).
- |101> (i101_r=4096) sent 5 cycles after the |000> vector -> second pulse with (r,i):
  - f000 = (1448, 0), f001 = (-1024, -1024), f010 = (0, 1448), f011 = (1024, -1024)
  - f100 = (-1448, 0), f101 = (1024, 1024), f110 = (0, -1448), f111 = (-1024, 1024)
- 8 consecutive cycles of basis states |0>..|7> -> 8 consecutive valid_out pulses in order.
  - Output for |j> has f_k = 1448·e^{iπjk/4} within ±2 LSB.
- rst asserted 3 cycles after valid_in -> no valid_out for that vector; f* = 0; a new vector after release returns correctly after 8 cycles.
- Input i000_r = i001_r = … = i111_r = 32767 -> f000_r saturates to 32767, other outputs ≈ 0 (±2); no wrap-around.

Source files
------------

// File: rtl/qft3_top.sv
// qft3_top: fully pipelined 3-qubit QFT (8-point DFT with e^{+i} twiddles,
// natural-order outputs). Accepts one vector per clock, 8-cycle latency.
// Rank map: 1 capture, 2 products, 3 pair sums, 4 quad sums, 5 full sums,
// 6 round, 7 saturate, 8 alignment, 9 output registers.
module qft3_top #(
  parameter int TOTAL_WIDTH = 16,
  parameter int FRAC_WIDTH  = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic signed [TOTAL_WIDTH-1:0] i000_r, i000_i, i001_r, i001_i,
  input  logic signed [TOTAL_WIDTH-1:0] i010_r, i010_i, i011_r, i011_i,
  input  logic signed [TOTAL_WIDTH-1:0] i100_r, i100_i, i101_r, i101_i,
  input  logic signed [TOTAL_WIDTH-1:0] i110_r, i110_i, i111_r, i111_i,
  output logic signed [TOTAL_WIDTH-1:0] f000_r, f000_i, f001_r, f001_i,
  output logic signed [TOTAL_WIDTH-1:0] f010_r, f010_i, f011_r, f011_i,
  output logic signed [TOTAL_WIDTH-1:0] f100_r, f100_i, f101_r, f101_i,
  output logic signed [TOTAL_WIDTH-1:0] f110_r, f110_i, f111_r, f111_i,
  output logic                          valid_out
);
  localparam int LATENCY = 8;
  localparam int TW = TOTAL_WIDTH;
  localparam int CF = FRAC_WIDTH + 8;  // twiddle fraction bits (20)
  localparam int AW = 2*TW + 8;        // accumulator width, headroom for 16 products
  localparam int RW = AW - CF;         // width after the rounding shift
  localparam logic signed [AW-1:0] ONE   = AW'(1);
  // Twiddle components with the 1/sqrt(8) normalisation folded in, scaled 2^20.
  // A finer scale than Q12 keeps every output within a fraction of an LSB.
  localparam logic signed [AW-1:0] K1    = AW'(370728);    // 1/sqrt(8)
  localparam logic signed [AW-1:0] KC    = ONE <<< (CF-2); // (1/sqrt2)/sqrt(8) = 1/4
  localparam logic signed [AW-1:0] HALF  = ONE <<< (CF-1);
  localparam logic signed [AW-1:0] HALFM = HALF - ONE;     // ties away from zero on negatives
  localparam logic signed [RW-1:0] SMAX  = RW'((1 << (TW-1)) - 1);
  localparam logic signed [RW-1:0] SMIN  = RW'(-(1 << (TW-1)));

  logic [LATENCY-1:0]   vld_d, vld_q;
  logic                 valid_out_d, valid_out_q;
  logic signed [TW-1:0] xr_d [8], xi_d [8], xr_q [8], xi_q [8];
  logic signed [AW-1:0] ar_d [8], ai_d [8], cr_d [8], ci_d [8];
  logic signed [AW-1:0] ar_q [8], ai_q [8], cr_q [8], ci_q [8];
  logic signed [AW-1:0] qr_d [4][8], qi_d [4][8], qr_q [4][8], qi_q [4][8];
  logic signed [AW-1:0] hr_d [2][8], hi_d [2][8], hr_q [2][8], hi_q [2][8];
  logic signed [AW-1:0] sr_d [8], si_d [8], sr_q [8], si_q [8];
  logic signed [RW-1:0] rr_d [8], ri_d [8], rr_q [8], ri_q [8];
  logic signed [TW-1:0] tr_d [8], ti_d [8], tr_q [8], ti_q [8];
  logic signed [TW-1:0] dr_d [8], di_d [8], dr_q [8], di_q [8];
  logic signed [TW-1:0] fr_d [8], fi_d [8], fr_q [8], fi_q [8];

  // x * W^m / sqrt(8) from the four precomputed products (a,b = Re,Im of x):
  // ar=a*K1, ai=b*K1, cr=a*KC, ci=b*KC.
  function automatic logic signed [AW-1:0] rot_re(input logic [2:0] m,
      input logic signed [AW-1:0] ar, ai, cr, ci);
    case (m)
      3'd0: return ar;
      3'd1: return cr - ci;
      3'd2: return -ai;
      3'd3: return -cr - ci;
      3'd4: return -ar;
      3'd5: return ci - cr;
      3'd6: return ai;
      default: return cr + ci;
    endcase
  endfunction

  function automatic logic signed [AW-1:0] rot_im(input logic [2:0] m,
      input logic signed [AW-1:0] ar, ai, cr, ci);
    case (m)
      3'd0: return ai;
      3'd1: return cr + ci;
      3'd2: return ar;
      3'd3: return cr - ci;
      3'd4: return -ai;
      3'd5: return -cr - ci;
      3'd6: return -ar;
      default: return ci - cr;
    endcase
  endfunction

  function automatic logic signed [TW-1:0] sat(input logic signed [RW-1:0] v);
    if (v > SMAX)      return TW'(SMAX);
    else if (v < SMIN) return TW'(SMIN);
    else               return TW'(v);
  endfunction

  // Valid pipeline and output hold: outputs change only when a result lands.
  always_comb begin
    vld_d       = {vld_q[LATENCY-2:0], valid_in};
    valid_out_d = vld_q[LATENCY-1];
    for (int k = 0; k < 8; k++) begin
      fr_d[k] = vld_q[LATENCY-1] ? dr_q[k] : fr_q[k];
      fi_d[k] = vld_q[LATENCY-1] ? di_q[k] : fi_q[k];
    end
  end

  // Gather the port amplitudes into index order j = 4X+2Y+Z.
  always_comb begin
    xr_d[0] = i000_r; xi_d[0] = i000_i; xr_d[1] = i001_r; xi_d[1] = i001_i;
    xr_d[2] = i010_r; xi_d[2] = i010_i; xr_d[3] = i011_r; xi_d[3] = i011_i;
    xr_d[4] = i100_r; xi_d[4] = i100_i; xr_d[5] = i101_r; xi_d[5] = i101_i;
    xr_d[6] = i110_r; xi_d[6] = i110_i; xr_d[7] = i111_r; xi_d[7] = i111_i;
  end

  // Four constant products per input amplitude cover every twiddle.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      ar_d[j] = AW'(xr_q[j]) * K1;
      ai_d[j] = AW'(xi_q[j]) * K1;
      cr_d[j] = AW'(xr_q[j]) * KC;
      ci_d[j] = AW'(xi_q[j]) * KC;
    end
  end

  // Pair sums: group g holds inputs 2g and 2g+1 rotated by W^(j*k mod 8).
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 8; k++) begin
        qr_d[g][k] = rot_re(3'((2*g)*k), ar_q[2*g], ai_q[2*g], cr_q[2*g], ci_q[2*g])
                   + rot_re(3'((2*g+1)*k), ar_q[2*g+1], ai_q[2*g+1], cr_q[2*g+1], ci_q[2*g+1]);
        qi_d[g][k] = rot_im(3'((2*g)*k), ar_q[2*g], ai_q[2*g], cr_q[2*g], ci_q[2*g])
                   + rot_im(3'((2*g+1)*k), ar_q[2*g+1], ai_q[2*g+1], cr_q[2*g+1], ci_q[2*g+1]);
      end
    end
  end

  // Adder tree, rounding shift and saturation, one rank each.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 2; h++) begin
        hr_d[h][k] = qr_q[2*h][k] + qr_q[2*h+1][k];
        hi_d[h][k] = qi_q[2*h][k] + qi_q[2*h+1][k];
      end
      sr_d[k] = hr_q[0][k] + hr_q[1][k];
      si_d[k] = hi_q[0][k] + hi_q[1][k];
      rr_d[k] = RW'((sr_q[k] + (sr_q[k][AW-1] ? HALFM : HALF)) >>> CF);
      ri_d[k] = RW'((si_q[k] + (si_q[k][AW-1] ? HALFM : HALF)) >>> CF);
      tr_d[k] = sat(rr_q[k]);
      ti_d[k] = sat(ri_q[k]);
      dr_d[k] = tr_q[k];
      di_d[k] = ti_q[k];
    end
  end

  // Datapath ranks: no reset needed, qualified by the valid pipeline.
  always_ff @(posedge clk) begin
    xr_q <= xr_d; xi_q <= xi_d;
    ar_q <= ar_d; ai_q <= ai_d; cr_q <= cr_d; ci_q <= ci_d;
    qr_q <= qr_d; qi_q <= qi_d;
    hr_q <= hr_d; hi_q <= hi_d;
    sr_q <= sr_d; si_q <= si_d;
    rr_q <= rr_d; ri_q <= ri_d;
    tr_q <= tr_d; ti_q <= ti_d;
    dr_q <= dr_d; di_q <= di_d;
  end

  // Control and output registers; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      valid_out_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        fr_q[k] <= '0;
        fi_q[k] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      valid_out_q <= valid_out_d;
      fr_q        <= fr_d;
      fi_q        <= fi_d;
    end
  end

  assign valid_out = valid_out_q;
  assign f000_r = fr_q[0]; assign f000_i = fi_q[0];
  assign f001_r = fr_q[1]; assign f001_i = fi_q[1];
  assign f010_r = fr_q[2]; assign f010_i = fi_q[2];
  assign f011_r = fr_q[3]; assign f011_i = fi_q[3];
  assign f100_r = fr_q[4]; assign f100_i = fi_q[4];
  assign f101_r = fr_q[5]; assign f101_i = fi_q[5];
  assign f110_r = fr_q[6]; assign f110_i = fi_q[6];
  assign f111_r = fr_q[7]; assign f111_i = fi_q[7];

endmodule

// File: tb/tb_qft3_top.sv
// Scoreboard bench for qft3_top: a real-valued DFT model queues expected
// outputs and their arrival cycle; a negedge monitor pops and compares.
module tb_qft3_top;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic valid_out;
  logic signed [15:0] in_r [8];
  logic signed [15:0] in_i [8];
  logic signed [15:0] out_r [8];
  logic signed [15:0] out_i [8];

  int vr [8];
  int vi [8];
  int cyc = 0;
  bit rst_seen = 1'b0;
  bit started = 1'b0;
  int checks = 0;
  int failures = 0;

  real er_q [$];
  real ei_q [$];
  int  tol_q [$];
  int  cyc_q [$];
  int  last_r [8];
  int  last_i [8];
  int  tol_m;
  bit  bad_m;

  qft3_top dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .i000_r(in_r[0]), .i000_i(in_i[0]), .i001_r(in_r[1]), .i001_i(in_i[1]),
    .i010_r(in_r[2]), .i010_i(in_i[2]), .i011_r(in_r[3]), .i011_i(in_i[3]),
    .i100_r(in_r[4]), .i100_i(in_i[4]), .i101_r(in_r[5]), .i101_i(in_i[5]),
    .i110_r(in_r[6]), .i110_i(in_i[6]), .i111_r(in_r[7]), .i111_i(in_i[7]),
    .f000_r(out_r[0]), .f000_i(out_i[0]), .f001_r(out_r[1]), .f001_i(out_i[1]),
    .f010_r(out_r[2]), .f010_i(out_i[2]), .f011_r(out_r[3]), .f011_i(out_i[3]),
    .f100_r(out_r[4]), .f100_i(out_i[4]), .f101_r(out_r[5]), .f101_i(out_i[5]),
    .f110_r(out_r[6]), .f110_i(out_i[6]), .f111_r(out_r[7]), .f111_i(out_i[7]),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  function automatic real clipr(input real x);
    if (x > 32767.0)  return 32767.0;
    if (x < -32768.0) return -32768.0;
    return x;
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Reference: f_k = (1/sqrt8) * sum_j x_j * exp(+i*2*pi*j*k/8), clipped.
  task automatic push_exp(input int tol);
    for (int k = 0; k < 8; k++) begin
      real sr, si, a;
      sr = 0.0;
      si = 0.0;
      for (int j = 0; j < 8; j++) begin
        a  = 2.0 * PI * $itor(j * k) / 8.0;
        sr = sr + $itor(vr[j]) * $cos(a) - $itor(vi[j]) * $sin(a);
        si = si + $itor(vr[j]) * $sin(a) + $itor(vi[j]) * $cos(a);
      end
      er_q.push_back(clipr(sr / $sqrt(8.0)));
      ei_q.push_back(clipr(si / $sqrt(8.0)));
    end
    tol_q.push_back(tol);
    cyc_q.push_back(cyc + 9);
  endtask

  task automatic pop_entry();
    void'(cyc_q.pop_front());
    void'(tol_q.pop_front());
    for (int k = 0; k < 8; k++) begin
      void'(er_q.pop_front());
      void'(ei_q.pop_front());
    end
  endtask

  task automatic chk(input string nm, input int k, input int act, input real ideal, input int tol);
    bit ok;
    checks++;
    if (tol == 0) ok = (act == rnd(ideal));
    else          ok = ($itor(act) >= ideal - tol) && ($itor(act) <= ideal + tol);
    if (!ok) begin
      failures++;
      $display("FAIL %s k=%0d cyc=%0d got=%0d want=%0.3f tol=%0d", nm, k, cyc, act, ideal, tol);
    end
  endtask

  // Monitor: flush on reset, then match each valid_out against the queue head.
  always @(negedge clk) begin
    if (rst_seen) begin
      started = 1'b1;
      while (cyc_q.size() > 0 && cyc_q[0] <= cyc + 8) pop_entry();
      for (int k = 0; k < 8; k++) begin
        last_r[k] = 0;
        last_i[k] = 0;
      end
    end
    if (started) begin
      if (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
        checks++; failures++;
        $display("FAIL missing_output due=%0d now=%0d", cyc_q[0], cyc);
        pop_entry();
      end
      if (valid_out) begin
        if (rst_seen || cyc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid cyc=%0d got=1 want=0", cyc);
        end else begin
          checks++;
          if (cyc_q[0] != cyc) begin
            failures++;
            $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, cyc_q[0]);
          end
          tol_m = tol_q[0];
          for (int k = 0; k < 8; k++) begin
            chk("f_re", k, int'(out_r[k]), er_q[k], tol_m);
            chk("f_im", k, int'(out_i[k]), ei_q[k], tol_m);
            last_r[k] = int'(out_r[k]);
            last_i[k] = int'(out_i[k]);
          end
          pop_entry();
        end
      end else begin
        checks++;
        bad_m = 1'b0;
        for (int k = 0; k < 8; k++)
          if (int'(out_r[k]) != last_r[k] || int'(out_i[k]) != last_i[k]) bad_m = 1'b1;
        if (bad_m) begin
          failures++;
          $display("FAIL hold cyc=%0d got f000=(%0d,%0d) want=(%0d,%0d)",
                   cyc, out_r[0], out_i[0], last_r[0], last_i[0]);
        end
      end
    end
  end

  task automatic step(input bit v, input bit r, input int tol);
    @(posedge clk);
    #1;
    rst      = r;
    valid_in = v;
    for (int j = 0; j < 8; j++) begin
      if (v) begin
        in_r[j] = 16'(vr[j]);
        in_i[j] = 16'(vi[j]);
      end else begin
        in_r[j] = 16'($urandom);
        in_i[j] = 16'($urandom);
      end
    end
    if (v && !r) push_exp(tol);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  task automatic set_basis(input int b);
    for (int j = 0; j < 8; j++) begin
      vr[j] = (j == b) ? 4096 : 0;
      vi[j] = 0;
    end
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    checks++;
    bad_m = valid_out;
    for (int k = 0; k < 8; k++)
      if (out_r[k] != 16'sd0 || out_i[k] != 16'sd0) bad_m = 1'b1;
    if (bad_m) begin
      failures++;
      $display("FAIL %s got valid=%0d f000=(%0d,%0d) f101=(%0d,%0d) want all 0",
               nm, valid_out, out_r[0], out_i[0], out_r[5], out_i[5]);
    end
  endtask

  int amp;

  initial begin
    for (int j = 0; j < 8; j++) begin
      in_r[j] = '0;
      in_i[j] = '0;
      vr[j] = 0;
      vi[j] = 0;
    end
    repeat (3) step(1'b0, 1'b1, 0);
    idle(10);
    check_zero("reset_state");

    // canonical basis vectors, exact
    set_basis(0); step(1'b1, 1'b0, 0);
    idle(4);
    set_basis(5); step(1'b1, 1'b0, 0);
    idle(12);

    // back-to-back basis states
    for (int b = 0; b < 8; b++) begin
      set_basis(b);
      step(1'b1, 1'b0, 2);
    end
    idle(12);

    // reset 3 cycles after a vector; a vector offered during reset is ignored
    set_basis(3); step(1'b1, 1'b0, 2);
    idle(2);
    step(1'b0, 1'b1, 0);
    set_basis(6); step(1'b1, 1'b1, 0);
    idle(3);
    check_zero("flush_zero");
    for (int j = 0; j < 8; j++) begin
      vr[j] = 1000 * j - 3000;
      vi[j] = 500 - 300 * j;
    end
    step(1'b1, 1'b0, 2);
    idle(12);

    // full scale saturates; zero in gives zero out
    for (int j = 0; j < 8; j++) begin vr[j] = 32767; vi[j] = 0; end
    step(1'b1, 1'b0, 2);
    for (int j = 0; j < 8; j++) begin vr[j] = -32768; vi[j] = -32768; end
    step(1'b1, 1'b0, 2);
    for (int j = 0; j < 8; j++) begin vr[j] = 0; vi[j] = 0; end
    step(1'b1, 1'b0, 0);
    idle(3);

    // randomized traffic with gaps and garbage on idle cycles
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 2))
          0:       amp = 4096;
          1:       amp = 16384;
          default: amp = 32768;
        endcase
        for (int j = 0; j < 8; j++) begin
          vr[j] = int'($urandom_range(0, 2 * amp - 1)) - amp;
          vi[j] = int'($urandom_range(0, 2 * amp - 1)) - amp;
        end
        step(1'b1, 1'b0, 2);
      end else begin
        step(1'b0, 1'b0, 0);
      end
    end

    for (int t = 0; t < 40 && cyc_q.size() > 0; t++) step(1'b0, 1'b0, 0);
    idle(2);
    checks++;
    if (cyc_q.size() != 0) begin
      failures++;
      $display("FAIL drain got_pending=%0d want=0", cyc_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
